// File: rtl/timer_down.sv
// mm:ss BCD count-down timer with adjust, pause/hold and alarm.
//
// state | meaning
// SETUP | digits adjustable, waiting for START edge
// RUN   | decrement on each TICK_1HZ
// HOLD  | paused, count frozen
// DONE  | reached 00:00, ALARM asserted
module timer_down #(
  parameter int PRESET_MIN = 0,
  parameter int PRESET_SEC = 0
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       TICK_1HZ,
  input  logic       TICK_2HZ,
  input  logic       START,
  input  logic       PAUSE,
  input  logic       ADJ,
  input  logic       SEL,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic [1:0] STATE,
  output logic       RUNNING,
  output logic       ALARM
);

  typedef enum logic [1:0] {
    SETUP = 2'b00,
    RUN   = 2'b01,
    HOLD  = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam logic [3:0] P_D0 = 4'(PRESET_SEC % 10);
  localparam logic [3:0] P_D1 = 4'(PRESET_SEC / 10);
  localparam logic [3:0] P_D2 = 4'(PRESET_MIN % 10);
  localparam logic [3:0] P_D3 = 4'(PRESET_MIN / 10);

  state_t     state_q, state_n;
  logic       start_prev;
  logic       start_edge;
  logic       is_zero;
  logic       is_one_sec;
  logic [3:0] n0, n1, n2, n3;

  // One 0-59 field as {tens, units}; wraps 59 -> 00 without carry out.
  function automatic logic [7:0] inc_field(input logic [3:0] tens, input logic [3:0] units);
    if (units == 4'd9) begin
      return (tens == 4'd5) ? 8'h00 : {tens + 4'd1, 4'd0};
    end
    return {tens, units + 4'd1};
  endfunction

  function automatic logic [15:0] dec_count(input logic [3:0] t3, input logic [3:0] t2,
                                            input logic [3:0] t1, input logic [3:0] t0);
    logic [3:0] r0, r1, r2, r3;
    r0 = t0; r1 = t1; r2 = t2; r3 = t3;
    if (t0 != 4'd0) begin
      r0 = t0 - 4'd1;
    end else begin
      r0 = 4'd9;
      if (t1 != 4'd0) begin
        r1 = t1 - 4'd1;
      end else begin
        r1 = 4'd5;
        if (t2 != 4'd0) begin
          r2 = t2 - 4'd1;
        end else begin
          r2 = 4'd9;
          r3 = t3 - 4'd1;
        end
      end
    end
    return {r3, r2, r1, r0};
  endfunction

  always_comb begin
    start_edge = START & ~start_prev;
    is_zero    = (d3 == 4'd0) && (d2 == 4'd0) && (d1 == 4'd0) && (d0 == 4'd0);
    is_one_sec = (d3 == 4'd0) && (d2 == 4'd0) && (d1 == 4'd0) && (d0 == 4'd1);
    state_n    = state_q;
    {n3, n2, n1, n0} = {d3, d2, d1, d0};
    case (state_q)
      SETUP: begin
        // an adjust increment wins over a coincident START edge
        if (ADJ && TICK_2HZ) begin
          if (SEL) {n1, n0} = inc_field(d1, d0);
          else     {n3, n2} = inc_field(d3, d2);
        end else if (start_edge && !is_zero) begin
          state_n = RUN;
        end
      end
      RUN: begin
        if (start_edge) begin
          state_n = SETUP;
        end else if (PAUSE) begin
          state_n = HOLD;
        end else if (TICK_1HZ && !is_zero) begin
          {n3, n2, n1, n0} = dec_count(d3, d2, d1, d0);
          if (is_one_sec) state_n = DONE;
        end
      end
      HOLD: begin
        if (start_edge)  state_n = SETUP;
        else if (!PAUSE) state_n = RUN;
      end
      DONE: begin
        if (start_edge || ADJ) state_n = SETUP;
      end
      default: state_n = SETUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q    <= SETUP;
      {d3, d2, d1, d0} <= {P_D3, P_D2, P_D1, P_D0};
      start_prev <= 1'b0;
      RUNNING    <= 1'b0;
      ALARM      <= 1'b0;
    end else begin
      state_q    <= state_n;
      {d3, d2, d1, d0} <= {n3, n2, n1, n0};
      start_prev <= START;
      RUNNING    <= (state_n == RUN);
      ALARM      <= (state_n == DONE);
    end
  end

  assign STATE = state_q;

endmodule

// File: tb/tb_timer_down.sv
// Scenario bench for timer_down: expectations queued from a seconds-based model, popped at each checkpoint.
module tb_timer_down;

  logic       clk = 1'b0;
  logic       RESET, TICK_1HZ, TICK_2HZ, START, PAUSE, ADJ, SEL;
  logic [3:0] d0, d1, d2, d3;
  logic [1:0] STATE;
  logic       RUNNING, ALARM;

  int checks = 0;
  int errors = 0;

  logic [17:0] exp_q[$];
  string       name_q[$];
  logic [17:0] e;
  string       nm;

  localparam logic [1:0] S_SETUP = 2'b00, S_RUN = 2'b01, S_HOLD = 2'b10, S_DONE = 2'b11;

  timer_down dut (
    .clk(clk), .RESET(RESET), .TICK_1HZ(TICK_1HZ), .TICK_2HZ(TICK_2HZ),
    .START(START), .PAUSE(PAUSE), .ADJ(ADJ), .SEL(SEL),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .STATE(STATE), .RUNNING(RUNNING), .ALARM(ALARM)
  );

  always #5 clk = ~clk;

  // Expected count kept as plain seconds; converted to BCD only for comparison.
  function automatic void push_exp(string n, int secs, logic [1:0] st);
    int m, s;
    m = secs / 60;
    s = secs % 60;
    exp_q.push_back({st, 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)});
    name_q.push_back(n);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic adj_tick(input int n);
    for (int i = 0; i < n; i++) begin
      TICK_2HZ = 1'b1; step(); TICK_2HZ = 1'b0; step();
    end
  endtask

  task automatic sec_tick(input int n);
    for (int i = 0; i < n; i++) begin
      TICK_1HZ = 1'b1; step(); TICK_1HZ = 1'b0; step();
    end
  endtask

  task automatic start_pulse();
    START = 1'b1; step(); START = 1'b0; step();
  endtask

  task automatic set_time(input int mm, input int ss);
    ADJ = 1'b1;
    SEL = 1'b1; adj_tick(ss);
    SEL = 1'b0; adj_tick(mm);
    ADJ = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; step(); RESET = 1'b0;
    push_exp("reset", 0, S_SETUP);
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if ({STATE, d3, d2, d1, d0} !== e || RUNNING !== 1'b0 || ALARM !== 1'b0) begin
      errors++;
      $display("FAIL %s: got st=%b %h%h:%h%h run=%b alm=%b, want %h", nm, STATE, d3, d2, d1, d0, RUNNING, ALARM, e);
    end
  endtask

  task automatic test_adjust();
    ADJ = 1'b1; SEL = 1'b1;
    adj_tick(60); push_exp("sec_wrap", 0, S_SETUP);
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if ({STATE, d3, d2, d1, d0} !== e) begin errors++; $display("FAIL %s: got %b_%h%h%h%h want %h", nm, STATE, d3, d2, d1, d0, e); end
    adj_tick(1); push_exp("sec_61", 1, S_SETUP);
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if ({STATE, d3, d2, d1, d0} !== e) begin errors++; $display("FAIL %s: got %b_%h%h%h%h want %h", nm, STATE, d3, d2, d1, d0, e); end
    ADJ = 1'b0; TICK_2HZ = 1'b1; TICK_1HZ = 1'b1; step(); TICK_2HZ = 1'b0; TICK_1HZ = 1'b0; step();
    push_exp("adj_off", 1, S_SETUP);
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if ({STATE, d3, d2, d1, d0} !== e) begin errors++; $display("FAIL %s: got %b_%h%h%h%h want %h", nm, STATE, d3, d2, d1, d0, e); end
    ADJ = 1'b1; SEL = 1'b0; adj_tick(3); push_exp("min_3", 3 * 60 + 1, S_SETUP);
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if ({STATE, d3, d2, d1, d0} !== e) begin errors++; $display("FAIL %s: got %b_%h%h%h%h want %h", nm, STATE, d3, d2, d1, d0, e); end
    adj_tick(57); push_exp("min_wrap", 1, S_SETUP);
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if ({STATE, d3, d2, d1, d0} !== e) begin errors++; $display("FAIL %s: got %b_%h%h%h%h want %h", nm, STATE, d3, d2, d1, d0, e); end
    ADJ = 1'b0;
  endtask

  task automatic test_run_to_done();
    set_time(1, 59);                       // 00:01 -> 01:00
    start_pulse(); push_exp("run_start", 60, S_RUN);
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if ({STATE, d3, d2, d1, d0} !== e || RUNNING !== 1'b1) begin errors++; $display("FAIL %s: got %b_%h%h%h%h run=%b want %h", nm, STATE, d3, d2, d1, d0, RUNNING, e); end
    sec_tick(1); push_exp("borrow_min", 59, S_RUN);
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if ({STATE, d3, d2, d1, d0} !== e) begin errors++; $display("FAIL %s: got %b_%h%h%h%h want %h", nm, STATE, d3, d2, d1, d0, e); end
    sec_tick(58); push_exp("one_left", 1, S_RUN);
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if ({STATE, d3, d2, d1, d0} !== e || ALARM !== 1'b0) begin errors++; $display("FAIL %s: got %b_%h%h%h%h alm=%b want %h", nm, STATE, d3, d2, d1, d0, ALARM, e); end
    TICK_1HZ = 1'b1; step(); push_exp("done_same_edge", 0, S_DONE);
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if ({STATE, d3, d2, d1, d0} !== e || ALARM !== 1'b1 || RUNNING !== 1'b0) begin errors++; $display("FAIL %s: got %b_%h%h%h%h alm=%b run=%b want %h", nm, STATE, d3, d2, d1, d0, ALARM, RUNNING, e); end
    TICK_1HZ = 1'b0; step();
    sec_tick(3); push_exp("done_hold", 0, S_DONE);
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if ({STATE, d3, d2, d1, d0} !== e || ALARM !== 1'b1) begin errors++; $display("FAIL %s: got %b_%h%h%h%h alm=%b want %h", nm, STATE, d3, d2, d1, d0, ALARM, e); end
    ADJ = 1'b1; step(); ADJ = 1'b0; push_exp("done_exit_adj", 0, S_SETUP);
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if ({STATE, d3, d2, d1, d0} !== e || ALARM !== 1'b0) begin errors++; $display("FAIL %s: got %b_%h%h%h%h alm=%b want %h", nm, STATE, d3, d2, d1, d0, ALARM, e); end
  endtask

  task automatic test_pause();
    set_time(0, 10);
    start_pulse();
    PAUSE = 1'b1; TICK_1HZ = 1'b1; step(); TICK_1HZ = 1'b0;
    push_exp("pause_no_dec", 10, S_HOLD);
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if ({STATE, d3, d2, d1, d0} !== e || RUNNING !== 1'b0) begin errors++; $display("FAIL %s: got %b_%h%h%h%h run=%b want %h", nm, STATE, d3, d2, d1, d0, RUNNING, e); end
    sec_tick(5); push_exp("hold_ticks", 10, S_HOLD);
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if ({STATE, d3, d2, d1, d0} !== e) begin errors++; $display("FAIL %s: got %b_%h%h%h%h want %h", nm, STATE, d3, d2, d1, d0, e); end
    PAUSE = 1'b0; step(); push_exp("resume", 10, S_RUN);
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if ({STATE, d3, d2, d1, d0} !== e) begin errors++; $display("FAIL %s: got %b_%h%h%h%h want %h", nm, STATE, d3, d2, d1, d0, e); end
    sec_tick(1); push_exp("resume_dec", 9, S_RUN);
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if ({STATE, d3, d2, d1, d0} !== e) begin errors++; $display("FAIL %s: got %b_%h%h%h%h want %h", nm, STATE, d3, d2, d1, d0, e); end
    start_pulse(); push_exp("run_to_setup", 9, S_SETUP);
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if ({STATE, d3, d2, d1, d0} !== e) begin errors++; $display("FAIL %s: got %b_%h%h%h%h want %h", nm, STATE, d3, d2, d1, d0, e); end
    set_time(10, 51);                      // 00:09 -> 10:00
    start_pulse(); sec_tick(1); push_exp("borrow_tens_min", 9 * 60 + 59, S_RUN);
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if ({STATE, d3, d2, d1, d0} !== e) begin errors++; $display("FAIL %s: got %b_%h%h%h%h want %h", nm, STATE, d3, d2, d1, d0, e); end
  endtask

  task automatic test_start_priority();
    RESET = 1'b1; step(); RESET = 1'b0;
    start_pulse(); push_exp("start_at_zero", 0, S_SETUP);
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if ({STATE, d3, d2, d1, d0} !== e) begin errors++; $display("FAIL %s: got %b_%h%h%h%h want %h", nm, STATE, d3, d2, d1, d0, e); end
    set_time(5, 30);
    start_pulse();
    START = 1'b1; TICK_1HZ = 1'b1; step(); START = 1'b0; TICK_1HZ = 1'b0;
    push_exp("start_beats_tick", 5 * 60 + 30, S_SETUP);
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if ({STATE, d3, d2, d1, d0} !== e) begin errors++; $display("FAIL %s: got %b_%h%h%h%h want %h", nm, STATE, d3, d2, d1, d0, e); end
    step();
    ADJ = 1'b1; SEL = 1'b1; TICK_2HZ = 1'b1; START = 1'b1; step();
    ADJ = 1'b0; TICK_2HZ = 1'b0; START = 1'b0; step();
    push_exp("start_with_adj", 5 * 60 + 31, S_SETUP);
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if ({STATE, d3, d2, d1, d0} !== e) begin errors++; $display("FAIL %s: got %b_%h%h%h%h want %h", nm, STATE, d3, d2, d1, d0, e); end
  endtask

  task automatic test_reset_override();
    start_pulse(); sec_tick(1);            // RUN at 05:30
    RESET = 1'b1; TICK_1HZ = 1'b1; step(); RESET = 1'b0; TICK_1HZ = 1'b0;
    push_exp("reset_mid_run", 0, S_SETUP);
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if ({STATE, d3, d2, d1, d0} !== e || RUNNING !== 1'b0) begin errors++; $display("FAIL %s: got %b_%h%h%h%h run=%b want %h", nm, STATE, d3, d2, d1, d0, RUNNING, e); end
    RESET = 1'b1; START = 1'b1; step(); RESET = 1'b0; step(); step();
    ADJ = 1'b1; SEL = 1'b1; adj_tick(3); ADJ = 1'b0; step(); step();
    push_exp("start_held_reset", 3, S_SETUP);
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if ({STATE, d3, d2, d1, d0} !== e) begin errors++; $display("FAIL %s: got %b_%h%h%h%h want %h", nm, STATE, d3, d2, d1, d0, e); end
    START = 1'b0; step(); START = 1'b1; step(); START = 1'b0;
    push_exp("start_after_release", 3, S_RUN);
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if ({STATE, d3, d2, d1, d0} !== e || RUNNING !== 1'b1) begin errors++; $display("FAIL %s: got %b_%h%h%h%h run=%b want %h", nm, STATE, d3, d2, d1, d0, RUNNING, e); end
  endtask

  initial begin
    RESET = 1'b1; TICK_1HZ = 1'b0; TICK_2HZ = 1'b0;
    START = 1'b0; PAUSE = 1'b0; ADJ = 1'b0; SEL = 1'b0;
    test_reset();
    test_adjust();
    test_run_to_done();
    test_pause();
    test_start_priority();
    test_reset_override();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
